// File: rtl/mips32_core.sv
// mips32_core: 5-stage (IF/ID/EX/MEM/WB) pipelined MIPS32 subset with a unified
// word-addressed instruction/data memory, EX-stage operand forwarding, branch
// resolution in EX with a two-slot flush, and a sticky halt.
//
// Ports:
//   clk1  - single clock, all state updates on the rising edge
//   rst_n - asynchronous active-low reset (clears PC, HALTED and the pipeline;
//           Reg and Mem keep their contents)
//
// Architectural state is exposed by name for hierarchical access:
//   Reg[0:31], Mem[0:MEM_WORDS-1], PC, HALTED, TAKEN_BRANCH
//
// Configuration macro: MIPS32_MUL_EN - when defined, MUL (000101) is
// implemented; when undefined, no multiplier exists and MUL behaves as NOP.
module mips32_core #(
    parameter int unsigned MEM_WORDS = 1024
) (
    input logic clk1,
    input logic rst_n
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    // Architectural state
    logic [XLEN-1:0] Reg [0:31];
    logic [XLEN-1:0] Mem [0:MEM_WORDS-1];
    logic [XLEN-1:0] PC;
    logic            HALTED;
    logic            TAKEN_BRANCH;

    // IF/ID
    logic [XLEN-1:0] if_id_ir_q, if_id_npc_q;
    logic            if_id_valid_q;
    // ID/EX
    logic [5:0]      id_ex_op_q;
    logic [4:0]      id_ex_rs_q, id_ex_rt_q, id_ex_dst_q;
    logic [XLEN-1:0] id_ex_a_q, id_ex_b_q, id_ex_imm_q, id_ex_npc_q;
    logic            id_ex_valid_q;
    // EX/MEM
    logic [5:0]      ex_mem_op_q;
    logic [4:0]      ex_mem_dst_q;
    logic [XLEN-1:0] ex_mem_alu_q, ex_mem_b_q;
    logic            ex_mem_valid_q;
    // MEM/WB
    logic [5:0]      mem_wb_op_q;
    logic [4:0]      mem_wb_dst_q;
    logic [XLEN-1:0] mem_wb_alu_q, mem_wb_lmd_q;
    logic            mem_wb_valid_q;

    // Opcodes whose ALU result is written to the register file
    function automatic logic writes_alu(input logic [5:0] op);
        logic w;
        w = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT,
            OP_ADDI, OP_SUBI, OP_SLTI: w = 1'b1;
`ifdef MIPS32_MUL_EN
            OP_MUL:                    w = 1'b1;
`endif
            default:                   w = 1'b0;
        endcase
        return w;
    endfunction

    // R-type instructions name their destination in rd, all others in rt
    function automatic logic is_rtype(input logic [5:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL};
    endfunction

    // ---------------- WB stage ----------------
    logic            wb_we;
    logic [XLEN-1:0] wb_val;

    assign wb_val = (mem_wb_op_q == OP_LW) ? mem_wb_lmd_q : mem_wb_alu_q;
    assign wb_we  = mem_wb_valid_q && !HALTED && (mem_wb_dst_q != 5'd0) &&
                    (writes_alu(mem_wb_op_q) || (mem_wb_op_q == OP_LW));

    // ---------------- ID stage ----------------
    logic [5:0]      id_op;
    logic [4:0]      id_rs, id_rt, id_dst;
    logic [XLEN-1:0] id_imm, id_a, id_b;

    assign id_op  = if_id_ir_q[31:26];
    assign id_rs  = if_id_ir_q[25:21];
    assign id_rt  = if_id_ir_q[20:16];
    assign id_dst = is_rtype(id_op) ? if_id_ir_q[15:11] : id_rt;
    assign id_imm = {{16{if_id_ir_q[15]}}, if_id_ir_q[15:0]};

    // Register read with write-through from the WB port; R0 is hardwired to zero
    always_comb begin
        id_a = Reg[id_rs];
        id_b = Reg[id_rt];
        if (id_rs == 5'd0)                         id_a = '0;
        else if (wb_we && (mem_wb_dst_q == id_rs)) id_a = wb_val;
        if (id_rt == 5'd0)                         id_b = '0;
        else if (wb_we && (mem_wb_dst_q == id_rt)) id_b = wb_val;
    end

    // ---------------- EX stage ----------------
    logic            mem_fwd;
    logic [XLEN-1:0] ex_a, ex_b, ex_alu, br_target;
    logic            ex_cond, halting;

    // Loads in EX/MEM are not forwarded: the load-use slot is software's job
    assign mem_fwd = ex_mem_valid_q && writes_alu(ex_mem_op_q) && (ex_mem_dst_q != 5'd0);

    // Youngest producer wins: EX/MEM first, then MEM/WB
    always_comb begin
        ex_a = id_ex_a_q;
        ex_b = id_ex_b_q;
        if (mem_fwd && (ex_mem_dst_q == id_ex_rs_q))     ex_a = ex_mem_alu_q;
        else if (wb_we && (mem_wb_dst_q == id_ex_rs_q))  ex_a = wb_val;
        if (mem_fwd && (ex_mem_dst_q == id_ex_rt_q))     ex_b = ex_mem_alu_q;
        else if (wb_we && (mem_wb_dst_q == id_ex_rt_q))  ex_b = wb_val;
    end

    // ALU; also forms the effective word address for LW/SW
    always_comb begin
        ex_alu = '0;
        case (id_ex_op_q)
            OP_ADD:  ex_alu = ex_a + ex_b;
            OP_SUB:  ex_alu = ex_a - ex_b;
            OP_AND:  ex_alu = ex_a & ex_b;
            OP_OR:   ex_alu = ex_a | ex_b;
            OP_SLT:  ex_alu = {31'd0, ($signed(ex_a) < $signed(ex_b))};
`ifdef MIPS32_MUL_EN
            OP_MUL:  ex_alu = ex_a * ex_b;
`endif
            OP_ADDI, OP_LW, OP_SW: ex_alu = ex_a + id_ex_imm_q;
            OP_SUBI: ex_alu = ex_a - id_ex_imm_q;
            OP_SLTI: ex_alu = {31'd0, ($signed(ex_a) < $signed(id_ex_imm_q))};
            default: ex_alu = '0;
        endcase
    end

    assign ex_cond   = ((id_ex_op_q == OP_BEQZ)  && (ex_a == '0)) ||
                       ((id_ex_op_q == OP_BNEQZ) && (ex_a != '0));
    // HLT sitting in WB freezes the machine from that edge onward
    assign halting   = HALTED || (mem_wb_valid_q && (mem_wb_op_q == OP_HLT));
    assign TAKEN_BRANCH = id_ex_valid_q && ex_cond && !halting;
    assign br_target = id_ex_npc_q + id_ex_imm_q;

    // ---------------- MEM stage / fetch addressing ----------------
    logic [AW-1:0]   mem_idx, pc_idx;
    logic            mem_we;
    logic [XLEN-1:0] pc_d;

    assign mem_idx = AW'(ex_mem_alu_q % XLEN'(MEM_WORDS));
    assign pc_idx  = AW'(PC % XLEN'(MEM_WORDS));
    assign mem_we  = ex_mem_valid_q && (ex_mem_op_q == OP_SW) && !halting;
    assign pc_d    = TAKEN_BRANCH ? br_target : PC + XLEN'(1);

    // Pipeline advance; a taken branch squashes the two younger slots
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            PC             <= '0;
            HALTED         <= 1'b0;
            if_id_ir_q     <= '0;
            if_id_npc_q    <= '0;
            if_id_valid_q  <= 1'b0;
            id_ex_op_q     <= '0;
            id_ex_rs_q     <= '0;
            id_ex_rt_q     <= '0;
            id_ex_dst_q    <= '0;
            id_ex_a_q      <= '0;
            id_ex_b_q      <= '0;
            id_ex_imm_q    <= '0;
            id_ex_npc_q    <= '0;
            id_ex_valid_q  <= 1'b0;
            ex_mem_op_q    <= '0;
            ex_mem_dst_q   <= '0;
            ex_mem_alu_q   <= '0;
            ex_mem_b_q     <= '0;
            ex_mem_valid_q <= 1'b0;
            mem_wb_op_q    <= '0;
            mem_wb_dst_q   <= '0;
            mem_wb_alu_q   <= '0;
            mem_wb_lmd_q   <= '0;
            mem_wb_valid_q <= 1'b0;
        end else if (halting) begin
            HALTED <= 1'b1;
        end else begin
            PC             <= pc_d;
            if_id_ir_q     <= Mem[pc_idx];
            if_id_npc_q    <= PC + XLEN'(1);
            if_id_valid_q  <= !TAKEN_BRANCH;

            id_ex_op_q     <= id_op;
            id_ex_rs_q     <= id_rs;
            id_ex_rt_q     <= id_rt;
            id_ex_dst_q    <= id_dst;
            id_ex_a_q      <= id_a;
            id_ex_b_q      <= id_b;
            id_ex_imm_q    <= id_imm;
            id_ex_npc_q    <= if_id_npc_q;
            id_ex_valid_q  <= if_id_valid_q && !TAKEN_BRANCH;

            ex_mem_op_q    <= id_ex_op_q;
            ex_mem_dst_q   <= id_ex_dst_q;
            ex_mem_alu_q   <= ex_alu;
            ex_mem_b_q     <= ex_b;
            ex_mem_valid_q <= id_ex_valid_q;

            mem_wb_op_q    <= ex_mem_op_q;
            mem_wb_dst_q   <= ex_mem_dst_q;
            mem_wb_alu_q   <= ex_mem_alu_q;
            mem_wb_lmd_q   <= Mem[mem_idx];
            mem_wb_valid_q <= ex_mem_valid_q;
        end
    end

    // Register file write port (contents survive reset)
    always_ff @(posedge clk1) begin
        if (wb_we) Reg[mem_wb_dst_q] <= wb_val;
    end

    // Memory write port (contents survive reset)
    always_ff @(posedge clk1) begin
        if (mem_we) Mem[mem_idx] <= ex_mem_b_q;
    end

endmodule

// File: tb/tb_mips32_core.sv
// tb_mips32_core: directed programs plus randomized straight-line programs for
// mips32_core, checked against constants and an instruction-level interpreter.
module tb_mips32_core;
    localparam int unsigned MEMW = 1024;
    localparam logic [31:0] NOPW = 32'hF800_0000;

    localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, ANDO = 6'b000010,
                           ORO = 6'b000011, SLT = 6'b000100, MUL = 6'b000101,
                           LW = 6'b001000, SW = 6'b001001, ADDI = 6'b001010,
                           SUBI = 6'b001011, SLTI = 6'b001100, BNEQZ = 6'b001101,
                           BEQZ = 6'b001110, HLT = 6'b111111;

    logic clk1 = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [31:0] mreg [32];
    logic [31:0] mmem [MEMW];

    mips32_core #(.MEM_WORDS(MEMW)) dut (.clk1(clk1), .rst_n(rst_n));

    always #5 clk1 = ~clk1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] op, input int rs, input int rt, input int rd);
        return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic put_word(input int addr, input logic [31:0] w);
        dut.Mem[addr] = w;
        mmem[addr]    = w;
    endtask

    task automatic set_reg(input int r, input logic [31:0] v);
        dut.Reg[r] = v;
        mreg[r]    = v;
    endtask

    // Hold reset, then blank memory with NOP words
    task automatic begin_test();
        rst_n = 1'b0;
        @(negedge clk1);
        for (int i = 0; i < int'(MEMW); i++) put_word(i, NOPW);
    endtask

    task automatic regs_k();
        for (int r = 0; r < 32; r++) set_reg(r, 32'(r));
    endtask

    task automatic go();
        @(negedge clk1);
        rst_n = 1'b1;
    endtask

    task automatic wait_halt(input string tag, input int budget, output int cycles, output int taken);
        cycles = 0;
        taken  = 0;
        while (dut.HALTED !== 1'b1 && cycles < budget) begin
            @(negedge clk1);
            cycles++;
            if (dut.TAKEN_BRANCH === 1'b1) taken++;
        end
        check({tag, "_halted"}, 32'(dut.HALTED), 32'd1);
    endtask

    // Sequential instruction-set interpreter over mreg/mmem
    task automatic run_model();
        int unsigned pc, npc;
        logic [31:0] ir, a, b, simm;
        logic [5:0]  op;
        int          rs, rt, rd;
        pc = 0;
        for (int step = 0; step < 5000; step++) begin
            ir   = mmem[pc % MEMW];
            op   = ir[31:26];
            rs   = int'(ir[25:21]);
            rt   = int'(ir[20:16]);
            rd   = int'(ir[15:11]);
            simm = {{16{ir[15]}}, ir[15:0]};
            a    = mreg[rs];
            b    = mreg[rt];
            npc  = pc + 1;
            if (op == HLT) break;
            case (op)
                ADD:  if (rd != 0) mreg[rd] = a + b;
                SUB:  if (rd != 0) mreg[rd] = a - b;
                ANDO: if (rd != 0) mreg[rd] = a & b;
                ORO:  if (rd != 0) mreg[rd] = a | b;
                SLT:  if (rd != 0) mreg[rd] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef MIPS32_MUL_EN
                MUL:  if (rd != 0) mreg[rd] = a * b;
`endif
                ADDI: if (rt != 0) mreg[rt] = a + simm;
                SUBI: if (rt != 0) mreg[rt] = a - simm;
                SLTI: if (rt != 0) mreg[rt] = ($signed(a) < $signed(simm)) ? 32'd1 : 32'd0;
                LW:   if (rt != 0) mreg[rt] = mmem[(a + simm) % MEMW];
                SW:   mmem[(a + simm) % MEMW] = b;
                BEQZ:  if (a == 0) npc = pc + 1 + simm;
                BNEQZ: if (a != 0) npc = pc + 1 + simm;
                default: ;
            endcase
            pc = npc;
        end
    endtask

    task automatic load_prog1();
        put_word(0, enc_i(ADDI, 0, 1, 10));
        put_word(1, enc_i(ADDI, 0, 2, 20));
        put_word(2, enc_i(ADDI, 0, 3, 25));
        put_word(3, enc_r(ORO, 7, 7, 7));
        put_word(4, enc_r(ORO, 7, 7, 7));
        put_word(5, enc_r(ADD, 1, 2, 4));
        put_word(6, enc_r(ORO, 7, 7, 7));
        put_word(7, enc_r(ADD, 4, 3, 5));
        put_word(8, enc_i(HLT, 0, 0, 0));
    endtask

    initial begin
        int cyc, tk;
        logic [31:0] w0;

        // Reset state
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_pc", dut.PC, 32'd0);
        check("rst_halted", 32'(dut.HALTED), 32'd0);
        check("rst_taken", 32'(dut.TAKEN_BRANCH), 32'd0);

        // Arithmetic program with padding
        begin_test();
        regs_k();
        load_prog1();
        go();
        wait_halt("t1", 100, cyc, tk);
        check("t1_latency_le14", 32'(cyc <= 14), 32'd1);
        check("t1_r1", dut.Reg[1], 32'd10);
        check("t1_r2", dut.Reg[2], 32'd20);
        check("t1_r3", dut.Reg[3], 32'd25);
        check("t1_r4", dut.Reg[4], 32'd30);
        check("t1_r5", dut.Reg[5], 32'd55);

        // Load / store
        begin_test();
        regs_k();
        put_word(120, 32'd85);
        put_word(0, enc_i(ADDI, 0, 3, 120));
        put_word(1, enc_r(ORO, 7, 7, 7));
        put_word(2, enc_i(LW, 3, 2, 0));
        put_word(3, enc_r(ORO, 7, 7, 7));
        put_word(4, enc_i(ADDI, 2, 2, 45));
        put_word(5, enc_i(SW, 3, 2, 1));
        put_word(6, enc_i(HLT, 0, 0, 0));
        go();
        wait_halt("t2", 100, cyc, tk);
        check("t2_mem121", dut.Mem[121], 32'd130);
        check("t2_r2", dut.Reg[2], 32'd130);

        // Factorial loop (MUL is a NOP when the multiplier is absent)
        begin_test();
        regs_k();
        put_word(200, 32'd7);
        put_word(0, enc_i(ADDI, 0, 10, 200));
        put_word(1, enc_i(ADDI, 0, 2, 1));
        put_word(2, enc_i(LW, 10, 3, 0));
        put_word(3, enc_r(ORO, 7, 7, 7));
        put_word(4, enc_r(MUL, 2, 3, 2));
        put_word(5, enc_i(SUBI, 3, 3, 1));
        put_word(6, enc_i(BNEQZ, 3, 0, -3));
        put_word(7, enc_i(ADDI, 9, 9, 1));
        put_word(8, enc_i(SW, 10, 2, -2));
        put_word(9, enc_i(HLT, 0, 0, 0));
        go();
        wait_halt("t3", 400, cyc, tk);
`ifdef MIPS32_MUL_EN
        check("t3_mem198", dut.Mem[198], 32'd5040);
`else
        check("t3_mem198", dut.Mem[198], 32'd1);
`endif
        check("t3_r3", dut.Reg[3], 32'd0);
        check("t3_r9_flush", dut.Reg[9], 32'd10);
        check("t3_taken_count", 32'(tk), 32'd6);

        // R0 immutability and no writes past HLT
        begin_test();
        regs_k();
        put_word(300, 32'h0000_DEAD);
        put_word(301, 32'h0000_1234);
        put_word(0, enc_i(ADDI, 0, 0, 5));
        put_word(1, enc_i(ADDI, 0, 1, 7));
        put_word(2, enc_i(HLT, 0, 0, 0));
        put_word(3, enc_i(SW, 0, 0, 301));
        put_word(4, enc_i(ADDI, 0, 1, 99));
        put_word(5, enc_i(ADDI, 0, 2, 55));
        put_word(6, enc_i(SW, 0, 1, 300));
        go();
        wait_halt("t4", 100, cyc, tk);
        repeat (10) @(negedge clk1);
        check("t4_r0", dut.Reg[0], 32'd0);
        check("t4_r1", dut.Reg[1], 32'd7);
        check("t4_r2", dut.Reg[2], 32'd2);
        check("t4_mem300", dut.Mem[300], 32'h0000_DEAD);
        check("t4_mem301", dut.Mem[301], 32'h0000_1234);
        check("t4_sticky", 32'(dut.HALTED), 32'd1);

        // Reset mid-program, then rerun
        begin_test();
        regs_k();
        load_prog1();
        w0 = enc_i(ADDI, 0, 1, 10);
        go();
        repeat (6) @(negedge clk1);
        rst_n = 1'b0;
        #1;
        check("t5_mid_pc", dut.PC, 32'd0);
        check("t5_mid_halted", 32'(dut.HALTED), 32'd0);
        check("t5_mid_r4", dut.Reg[4], 32'd4);
        check("t5_mid_r5", dut.Reg[5], 32'd5);
        check("t5_mem0", dut.Mem[0], w0);
        go();
        wait_halt("t5", 100, cyc, tk);
        check("t5_r4", dut.Reg[4], 32'd30);
        check("t5_r5", dut.Reg[5], 32'd55);
        @(negedge clk1);
        rst_n = 1'b0;
        #1;
        check("t5_post_halted", 32'(dut.HALTED), 32'd0);
        check("t5_post_pc", dut.PC, 32'd0);
        check("t5_mem8", dut.Mem[8], enc_i(HLT, 0, 0, 0));

        // Randomized straight-line programs against the interpreter
        for (int it = 0; it < 3; it++) begin
            int pc;
            begin_test();
            for (int r = 0; r < 32; r++) set_reg(r, (r == 0) ? 32'd0 : 32'($urandom));
            for (int i = 512; i < 576; i++) put_word(i, 32'($urandom));
            pc = 0;
            for (int n = 0; n < 24; n++) begin
                int kind;
                kind = int'($urandom_range(0, 9));
                if (kind <= 5) begin
                    put_word(pc, enc_r(6'(kind), int'($urandom_range(0, 31)),
                                       int'($urandom_range(0, 31)), int'($urandom_range(0, 31))));
                end else if (kind <= 8) begin
                    put_word(pc, enc_i(6'(10 + kind - 6), int'($urandom_range(0, 31)),
                                       int'($urandom_range(0, 31)), int'($urandom_range(0, 65535))));
                end else if ($urandom_range(0, 1) == 1) begin
                    put_word(pc, enc_i(SW, 0, int'($urandom_range(0, 31)), 512 + int'($urandom_range(0, 63))));
                end else begin
                    put_word(pc, enc_i(LW, 0, int'($urandom_range(0, 31)), 512 + int'($urandom_range(0, 63))));
                    pc++;
                    put_word(pc, enc_i(ADDI, 0, 0, 0));
                end
                pc++;
            end
            put_word(pc, enc_i(HLT, 0, 0, 0));
            run_model();
            go();
            wait_halt($sformatf("rnd%0d", it), 400, cyc, tk);
            repeat (5) @(negedge clk1);
            for (int r = 0; r < 32; r++)
                check($sformatf("rnd%0d_r%0d", it, r), dut.Reg[r], mreg[r]);
            for (int i = 512; i < 576; i++)
                check($sformatf("rnd%0d_m%0d", it, i), dut.Mem[i], mmem[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
